tc_digital_io_bank: RTL
=======================

Name: tc_digital_io_bank

Overview:
- Parametrised bank of NumPads digital pad channels.
- Registers the chip->pad path: data, output enable, drive strength and pulls.
- Conditions the pad->chip path: synchroniser, optional per-pad debounce, and rising/falling edge detection with sticky interrupt flags.
- Sits between core GPIO/peripheral logic and the generic pad cells, one instance per pad group.

Parameters:
NumPads, 8, number of pad channels (>=1)
SyncStages, 2, synchroniser flops on each pad input (>=2)
DebounceCycles, 4, consecutive stable cycles required before a debounced input updates (>=2)
DriveWidth, 4, drive-strength field width per pad

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
out_data_i  input  NumPads  core value to drive per pad
out_en_i  input  NumPads  1 = pad driven by chip
drive_strength_i  input  NumPads*DriveWidth  per-pad drive strength
pullup_en_i  input  NumPads  pull-up request
pulldown_en_i  input  NumPads  pull-down request
debounce_en_i  input  NumPads  1 = debounce filter active
rise_irq_en_i  input  NumPads  enable rising-edge interrupt
fall_irq_en_i  input  NumPads  enable falling-edge interrupt
irq_clear_i  input  NumPads  write-1-to-clear pending flags (pulse)
in_data_o  output  NumPads  conditioned input value
irq_pending_o  output  NumPads  sticky per-pad interrupt flags
irq_o  output  1  OR of irq_pending_o
pad_data_o  output  NumPads  to pad cell data input
pad_oe_no  output  NumPads  to pad cell, 0 = drive, 1 = hi-Z
pad_drive_o  output  NumPads*DriveWidth  to pad cell drive strength
pad_pullup_o  output  NumPads  to pad cell pull-up enable
pad_pulldown_o  output  NumPads  to pad cell pull-down enable
pad_data_i  input  NumPads  from pad cell, asynchronous

Behaviour:
- Reset values, all applied asynchronously on rst_i:
  - pad_oe_no all 1 (hi-Z); pad_data_o, pad_drive_o, pad_pullup_o, pad_pulldown_o all 0.
  - Synchroniser flops, debounce counters, in_data_o and irq_pending_o all 0; irq_o=0.
- Reset mid-operation discards any in-progress debounce count and any pending flags.
- Output path: registered, 1-cycle latency.
  - pad_oe_no <= ~out_en_i; pad_data_o <= out_data_i; pad_drive_o <= drive_strength_i.
  - All three update on the same edge, so there is never a driven cycle with stale data.
- Pulls: registered, 1 cycle.
  - Pull-up and pull-down both requested on a pad -> both outputs 0 for that pad.
  - Otherwise pad_pullup_o <= pullup_en_i and pad_pulldown_o <= pulldown_en_i.
- Input path, per pad:
  - pad_data_i passes through SyncStages flops; s = last stage; q = stable register driving in_data_o.
  - Bypass (debounce_en_i=0): q <= s every cycle. Latency from a pad change to in_data_o is SyncStages+1 edges.
  - Debounce (debounce_en_i=1): counter width $clog2(DebounceCycles).
    - s == q: counter <= 0.
    - s != q and counter == DebounceCycles-1: q <= s, counter <= 0.
    - Otherwise counter increments.
    - A glitch shorter than DebounceCycles cycles never reaches q. Latency is SyncStages+DebounceCycles edges.
  - Toggling debounce_en_i clears that pad's counter.
- The input is sampled even while the pad is driven (readback); edges caused by the pad's own output raise interrupts normally.
- Edge detection: rise = q_next & ~q; fall = ~q_next & q.
  - pending <= pending | (rise & rise_irq_en_i) | (fall & fall_irq_en_i).
  - Then flags with irq_clear_i set are cleared, except that a set in the same cycle wins over a clear.
  - irq_pending_o changes on the same edge as the in_data_o change. irq_o is combinational OR of the flags.
- Enabling an interrupt does not retro-flag an earlier edge.

Test Plan:
All scenarios use NumPads=4, SyncStages=2, DebounceCycles=4.
1. Hold rst_i=1, with pad_data_i=4'hF and out_en_i=4'hF -> pad_oe_no=4'hF, pad_data_o=0, in_data_o=0, irq_o=0. Release rst_i -> 1 edge later pad_oe_no=4'h0.
2. out_en_i=4'b0001, out_data_i=4'b0001 applied before edge 1 -> after edge 1 pad_oe_no=4'b1110, pad_data_o=4'b0001. Deassert out_en_i -> pad_oe_no=4'hF after next edge.
3. Pad 1 in bypass, rise_irq_en_i[1]=1; pad_data_i[1] 0->1 -> in_data_o[1]=1 and irq_pending_o[1]=1, irq_o=1 after 3 edges. irq_clear_i[1] pulse -> flag 0 next edge.
4. Pad 2 in debounce: high for 3 cycles, then low -> in_data_o[2] stays 0, no irq. Held high continuously -> in_data_o[2]=1 after 6 edges.
5. Pad 3 falling edge with fall_irq_en_i[3]=1, and irq_clear_i[3]=1 on the edge where the flag sets -> irq_pending_o[3] remains 1.
6. pullup_en_i=pulldown_en_i=4'b0100 -> pad_pullup_o[2]=pad_pulldown_o[2]=0. Assert rst_i mid-debounce (count 2) -> counter 0; after release the filter needs a fresh 4 stable cycles.

Source files
------------

// File: rtl/tc_digital_io_bank.sv
// Bank of digital pad channels: registered chip->pad controls and a conditioned
// pad->chip path (synchroniser, optional debounce, edge-triggered sticky interrupts).
module tc_digital_io_bank #(
    parameter int NumPads        = 8,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 4,
    parameter int DriveWidth     = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumPads-1:0]             out_data_i,
    input  logic [NumPads-1:0]             out_en_i,
    input  logic [NumPads*DriveWidth-1:0]  drive_strength_i,
    input  logic [NumPads-1:0]             pullup_en_i,
    input  logic [NumPads-1:0]             pulldown_en_i,
    input  logic [NumPads-1:0]             debounce_en_i,
    input  logic [NumPads-1:0]             rise_irq_en_i,
    input  logic [NumPads-1:0]             fall_irq_en_i,
    input  logic [NumPads-1:0]             irq_clear_i,
    output logic [NumPads-1:0]             in_data_o,
    output logic [NumPads-1:0]             irq_pending_o,
    output logic                           irq_o,
    output logic [NumPads-1:0]             pad_data_o,
    output logic [NumPads-1:0]             pad_oe_no,
    output logic [NumPads*DriveWidth-1:0]  pad_drive_o,
    output logic [NumPads-1:0]             pad_pullup_o,
    output logic [NumPads-1:0]             pad_pulldown_o,
    input  logic [NumPads-1:0]             pad_data_i
);

    localparam int CntW = $clog2(DebounceCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    logic [NumPads-1:0] r_sync [SyncStages];
    logic [NumPads-1:0] r_q;
    logic [NumPads-1:0] r_deb_en;
    logic [NumPads-1:0] r_pending;
    logic [CntW-1:0]    r_cnt [NumPads];

    logic [NumPads-1:0] w_s;
    logic [NumPads-1:0] w_q_next;
    logic [NumPads-1:0] w_rise;
    logic [NumPads-1:0] w_fall;
    logic [NumPads-1:0] w_set;
    logic [CntW-1:0]    w_cnt_next [NumPads];

    // Chip->pad controls; data, enable and drive share one edge so a driven pad never shows stale data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pad_oe_no      <= '1;
            pad_data_o     <= '0;
            pad_drive_o    <= '0;
            pad_pullup_o   <= '0;
            pad_pulldown_o <= '0;
        end else begin
            pad_oe_no      <= ~out_en_i;
            pad_data_o     <= out_data_i;
            pad_drive_o    <= drive_strength_i;
            pad_pullup_o   <= pullup_en_i & ~pulldown_en_i;
            pad_pulldown_o <= pulldown_en_i & ~pullup_en_i;
        end
    end

    // Input synchroniser chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SyncStages; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= pad_data_i;
            for (int i = 1; i < SyncStages; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SyncStages-1];

    // Per-pad filter: a mode change restarts the count, debounce only commits after a full stable window.
    always_comb begin
        w_q_next = r_q;
        for (int p = 0; p < NumPads; p++) begin
            w_cnt_next[p] = r_cnt[p];
            if (debounce_en_i[p] != r_deb_en[p]) begin
                w_cnt_next[p] = '0;
                if (!debounce_en_i[p]) begin
                    w_q_next[p] = w_s[p];
                end else begin
                    w_q_next[p] = r_q[p];
                end
            end else if (!debounce_en_i[p]) begin
                w_q_next[p]   = w_s[p];
                w_cnt_next[p] = '0;
            end else if (w_s[p] == r_q[p]) begin
                w_cnt_next[p] = '0;
            end else if (r_cnt[p] == CntMax) begin
                w_q_next[p]   = w_s[p];
                w_cnt_next[p] = '0;
            end else begin
                w_cnt_next[p] = r_cnt[p] + CntW'(1);
            end
        end
    end

    assign w_rise = w_q_next & ~r_q;
    assign w_fall = ~w_q_next & r_q;
    assign w_set  = (w_rise & rise_irq_en_i) | (w_fall & fall_irq_en_i);

    // Stable value, counters and sticky flags; a new edge beats a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q       <= '0;
            r_deb_en  <= '0;
            r_pending <= '0;
            for (int p = 0; p < NumPads; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            r_q       <= w_q_next;
            r_deb_en  <= debounce_en_i;
            r_pending <= (r_pending & ~irq_clear_i) | w_set;
            for (int p = 0; p < NumPads; p++) begin
                r_cnt[p] <= w_cnt_next[p];
            end
        end
    end

    assign in_data_o     = r_q;
    assign irq_pending_o = r_pending;
    assign irq_o         = |r_pending;

endmodule
